// File: rtl/parallel_word_packer.sv
// -----------------------------------------------------------------------------
// parallel_word_packer
//
// Width up-converter in front of the parallel-shift split FIFO. Items of
// SPLIT_WIDTH bits arrive one per handshake and are packed into a word of
// NUM_SPLITS lanes. Item 0 goes to lane 0, which is bits SPLIT_WIDTH-1:0. The
// FIFO reads split 0 first, so items leave downstream in arrival order.
//
// A word is pushed when its last lane is written, or earlier on flush. On a
// flush, lanes that were never written keep PAD_VALUE.
//
// Ports
//   clk        single clock, all state on posedge
//   rstb       asynchronous active-low reset
//   inValid    upstream item present
//   inData     upstream item
//   inReady    packer accepts an item this cycle (high only in FILL)
//   flush      push the partially filled word, padded
//   fifoFull   downstream FIFO full; stalls the push while high
//   valid      one-cycle push strobe per word
//   data       packed word (registered)
//   busy       a lane is filled or a word is pending
//   wordCount  words pushed since reset, wraps
//   dbgState   FSM state (0 = FILL, 1 = HOLD)
//
// Handshake: an item transfers on a rising clk edge where inValid & inReady
// are both high. inValid may be raised while inReady is low. The item is then
// taken on the first edge where inReady is high, and inData must be held until
// that edge. The downstream side has no ready input. valid is a strobe that
// fires only when fifoFull is low, and a word is consumed on every edge where
// valid is high.
// -----------------------------------------------------------------------------
module parallel_word_packer #(
  parameter int unsigned             SPLIT_WIDTH          = 32,
  parameter int unsigned             NUM_SPLITS           = 8,
  parameter int unsigned             NUM_SPLITS_BIT_WIDTH = 3,
  parameter logic [SPLIT_WIDTH-1:0]  PAD_VALUE            = '0,
  parameter int unsigned             COUNT_WIDTH          = 32
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              inValid,
  input  logic [SPLIT_WIDTH-1:0]            inData,
  output logic                              inReady,
  input  logic                              flush,
  input  logic                              fifoFull,
  output logic                              valid,
  output logic [NUM_SPLITS*SPLIT_WIDTH-1:0] data,
  output logic                              busy,
  output logic [COUNT_WIDTH-1:0]            wordCount,
  output logic                              dbgState
);

  localparam int unsigned WORD_WIDTH = NUM_SPLITS * SPLIT_WIDTH;
  localparam logic [NUM_SPLITS_BIT_WIDTH-1:0] LAST_LANE =
    NUM_SPLITS_BIT_WIDTH'(NUM_SPLITS - 1);
  localparam logic [WORD_WIDTH-1:0] PAD_WORD = {NUM_SPLITS{PAD_VALUE}};

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_SPLITS_BIT_WIDTH-1:0] lane_idx_q, lane_idx_d;
  logic [WORD_WIDTH-1:0]           lanes_q, lanes_d;
  logic [COUNT_WIDTH-1:0]          count_q, count_d;
  logic                            accept;
  logic                            push;

  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    lanes_d    = lanes_q;
    count_d    = count_q;
    accept     = 1'b0;
    push       = 1'b0;
    if (state_q == ST_FILL) begin
      accept = inValid;
      if (accept) begin
        lanes_d[lane_idx_q*SPLIT_WIDTH +: SPLIT_WIDTH] = inData;
      end
      // A last-lane accept and a flush in the same cycle close the same
      // word, so only one push results. A flush with nothing accumulated
      // and nothing arriving is ignored.
      if ((accept && (lane_idx_q == LAST_LANE)) ||
          (flush && ((lane_idx_q != '0) || accept))) begin
        state_d    = ST_HOLD;
        lane_idx_d = '0;
      end else if (accept) begin
        lane_idx_d = lane_idx_q + NUM_SPLITS_BIT_WIDTH'(1);
      end
    end else begin
      push = ~fifoFull;
      if (push) begin
        // Clearing the lanes on the push edge means that a later flush
        // pads with PAD_VALUE, and data never changes while valid is high.
        state_d = ST_FILL;
        lanes_d = PAD_WORD;
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_FILL;
      lane_idx_q <= '0;
      lanes_q    <= PAD_WORD;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      lanes_q    <= lanes_d;
      count_q    <= count_d;
    end
  end

  assign inReady   = (state_q == ST_FILL);
  assign valid     = push;
  assign data      = lanes_q;
  assign busy      = (state_q == ST_HOLD) || (lane_idx_q != '0);
  assign wordCount = count_q;
  assign dbgState  = (state_q == ST_HOLD);

endmodule
